// File: rtl/seq_program_loader.sv
// Boot loader: frames a host byte stream into 16-bit instructions, writes them to instruction
// memory and brackets the load with core stop/start pulses. Optional CHK byte: LOADER_CHECKSUM_EN.
module seq_program_loader #(
    parameter int ADDRESS_SIZE     = 10,
    parameter int INSTRUCTION_SIZE = 16,
    parameter int HALT_CYCLES      = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_byte_valid,
    input  logic [7:0]                  i_byte,
    output logic                        o_byte_ready,
    output logic                        o_imem_write,
    output logic [ADDRESS_SIZE-1:0]     o_imem_address,
    output logic [INSTRUCTION_SIZE-1:0] o_imem_data,
    output logic                        o_sys_stop,
    output logic                        o_sys_start,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_error
);

    localparam int                CNT_W     = ADDRESS_SIZE + 1;
    localparam int                HALT_W    = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;
    localparam logic [HALT_W-1:0] HALT_LAST = HALT_W'(HALT_CYCLES - 1);
    localparam logic [16:0]       MAX_WORDS = 17'(1 << ADDRESS_SIZE);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_HALT    = 4'd1,
        ST_LEN_LO  = 4'd2,
        ST_LEN_HI  = 4'd3,
        ST_DATA_LO = 4'd4,
        ST_DATA_HI = 4'd5,
        ST_START   = 4'd6,
        ST_ERROR   = 4'd7
`ifdef LOADER_CHECKSUM_EN
        , ST_CHK   = 4'd8
`endif
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t ST_AFTER_DATA = ST_CHK;
`else
    localparam state_t ST_AFTER_DATA = ST_START;
`endif

    state_t                        state_r;
    state_t                        state_next_s;
    logic [HALT_W-1:0]             halt_cnt_r;
    logic [7:0]                    lo_r;
    logic [CNT_W-1:0]              n_words_r;
    logic [CNT_W-1:0]              word_idx_r;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]                    xor_r;
`endif
    logic                          ready_r;
    logic                          write_r;
    logic [ADDRESS_SIZE-1:0]       addr_r;
    logic [INSTRUCTION_SIZE-1:0]   data_r;
    logic                          stop_r;
    logic                          start_r;
    logic                          busy_r;
    logic                          error_r;
    logic                          xfer_s;
    logic                          last_word_s;
    logic [15:0]                   len_word_s;

    assign xfer_s      = i_byte_valid && ready_r;
    assign len_word_s  = {i_byte, lo_r};
    assign last_word_s = (word_idx_r == (n_words_r - CNT_W'(1)));

    function automatic logic accepts_bytes(input state_t s);
        case (s)
            ST_LEN_LO, ST_LEN_HI, ST_DATA_LO, ST_DATA_HI: accepts_bytes = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            ST_CHK:                                       accepts_bytes = 1'b1;
`endif
            default:                                      accepts_bytes = 1'b0;
        endcase
    endfunction

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; ERROR is absorbing until reset
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_byte_valid) state_next_s = ST_HALT;
                else              state_next_s = ST_IDLE;
            end
            ST_HALT: begin
                if (halt_cnt_r == HALT_LAST) state_next_s = ST_LEN_LO;
                else                         state_next_s = ST_HALT;
            end
            ST_LEN_LO: begin
                if (xfer_s) state_next_s = ST_LEN_HI;
                else        state_next_s = ST_LEN_LO;
            end
            ST_LEN_HI: begin
                if (!xfer_s)                         state_next_s = ST_LEN_HI;
                else if ({1'b0, len_word_s} > MAX_WORDS) state_next_s = ST_ERROR;
                else if (len_word_s == 16'd0)        state_next_s = ST_AFTER_DATA;
                else                                 state_next_s = ST_DATA_LO;
            end
            ST_DATA_LO: begin
                if (xfer_s) state_next_s = ST_DATA_HI;
                else        state_next_s = ST_DATA_LO;
            end
            ST_DATA_HI: begin
                if (!xfer_s)         state_next_s = ST_DATA_HI;
                else if (last_word_s) state_next_s = ST_AFTER_DATA;
                else                 state_next_s = ST_DATA_LO;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (!xfer_s)              state_next_s = ST_CHK;
                else if (i_byte == xor_r) state_next_s = ST_START;
                else                      state_next_s = ST_ERROR;
            end
`endif
            ST_START: state_next_s = ST_IDLE;
            ST_ERROR: state_next_s = ST_ERROR;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Framing datapath: halt timer, byte latch, word count and index
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            halt_cnt_r <= '0;
            lo_r       <= 8'h00;
            n_words_r  <= '0;
            word_idx_r <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_r      <= 8'h00;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    halt_cnt_r <= '0;
                    word_idx_r <= '0;
`ifdef LOADER_CHECKSUM_EN
                    xor_r      <= 8'h00;
`endif
                end
                ST_HALT: halt_cnt_r <= halt_cnt_r + HALT_W'(1);
                ST_LEN_LO: begin
                    if (xfer_s) lo_r <= i_byte;
                end
                ST_LEN_HI: begin
                    if (xfer_s) n_words_r <= CNT_W'(len_word_s);
                end
                ST_DATA_LO: begin
                    if (xfer_s) begin
                        lo_r  <= i_byte;
`ifdef LOADER_CHECKSUM_EN
                        xor_r <= xor_r ^ i_byte;
`endif
                    end
                end
                ST_DATA_HI: begin
                    if (xfer_s) begin
                        word_idx_r <= word_idx_r + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                        xor_r      <= xor_r ^ i_byte;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs; the write strobe lands the cycle after the high byte is taken
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_r <= 1'b0;
            write_r <= 1'b0;
            addr_r  <= '0;
            data_r  <= '0;
            stop_r  <= 1'b0;
            start_r <= 1'b0;
            busy_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            ready_r <= accepts_bytes(state_next_s);
            write_r <= (state_r == ST_DATA_HI) && xfer_s;
            if ((state_r == ST_DATA_HI) && xfer_s) begin
                addr_r <= word_idx_r[ADDRESS_SIZE-1:0];
                data_r <= INSTRUCTION_SIZE'({i_byte, lo_r});
            end
            stop_r  <= (state_r == ST_IDLE) && i_byte_valid;
            start_r <= (state_r == ST_START);
            busy_r  <= (state_next_s != ST_IDLE) && (state_next_s != ST_ERROR);
            error_r <= (state_next_s == ST_ERROR);
        end
    end

    assign o_byte_ready   = ready_r;
    assign o_imem_write   = write_r;
    assign o_imem_address = addr_r;
    assign o_imem_data    = data_r;
    assign o_sys_stop     = stop_r;
    assign o_sys_start    = start_r;
    assign o_done         = start_r;
    assign o_busy         = busy_r;
    assign o_error        = error_r;

endmodule
